// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like instruction/data arbiter.
package sram_like_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data sram-like masters onto one slave port,
// one transaction outstanding, data-priority with an instruction starvation guard.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    state_e           r_state;
    state_e           w_state_nxt;
    owner_e           r_owner;
    owner_e           w_sel;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_req;
    logic             w_hs;
    logic             w_inst_prio;

    assign w_inst_prio = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Selection is live only in IDLE; ADDR freezes the registered owner.
    always_comb begin
        w_sel = r_owner;
        w_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = inst_req | data_req;
                if (inst_req && (!data_req || w_inst_prio))
                    w_sel = OWN_INST;
                else if (data_req)
                    w_sel = OWN_DATA;
            end
            ST_ADDR: begin
                w_req = (r_owner == OWN_INST) ? inst_req : data_req;
            end
            default: ;
        endcase
        // Keep the slave request quiet while reset is held, even if masters are asserting.
        w_req = w_req & resetn;
    end

    assign w_hs = w_req & addr_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_state_nxt = addr_ok ? ST_DATA : ST_ADDR;
            ST_ADDR: begin
                if (!w_req)
                    w_state_nxt = ST_IDLE;
                else if (addr_ok)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: if (data_ok) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_hs) begin
            if ((w_sel == OWN_DATA) && inst_req)
                w_cnt_nxt = (r_starve_cnt == '1) ? r_starve_cnt : r_starve_cnt + 1'b1;
            else
                w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_DATA;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_cnt_nxt;
            if ((r_state == ST_IDLE) && w_req)
                r_owner <= w_sel;
        end
    end

    assign req   = w_req;
    assign wr    = (w_sel == OWN_INST) ? inst_wr    : data_wr;
    assign size  = (w_sel == OWN_INST) ? inst_size  : data_size;
    assign addr  = (w_sel == OWN_INST) ? inst_addr  : data_addr;
    assign wdata = (w_sel == OWN_INST) ? inst_wdata : data_wdata;

    assign inst_addr_ok = w_hs & (w_sel == OWN_INST);
    assign data_addr_ok = w_hs & (w_sel == OWN_DATA);

    assign inst_data_ok = data_ok & (r_state == ST_DATA) & (r_owner == OWN_INST);
    assign data_data_ok = data_ok & (r_state == ST_DATA) & (r_owner == OWN_DATA);

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter with hand-computed expectations.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int n_checks;
    int n_errors;

    sram_like_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .addr         (addr),
        .wdata        (wdata),
        .addr_ok      (addr_ok),
        .data_ok      (data_ok),
        .rdata        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        resetn     = 1'b0;
        inst_req   = 1'b0; inst_wr = 1'b0; inst_size = SZ_WORD;
        inst_addr  = '0;   inst_wdata = '0;
        data_req   = 1'b0; data_wr = 1'b0; data_size = SZ_WORD;
        data_addr  = '0;   data_wdata = '0;
        addr_ok    = 1'b0; data_ok = 1'b0; rdata = '0;
        #2;
        check("rst_req",    32'(req), 0);
        check("rst_iaok",   32'(inst_addr_ok), 0);
        check("rst_daok",   32'(data_addr_ok), 0);
        check("rst_idok",   32'(inst_data_ok), 0);
        check("rst_ddok",   32'(data_data_ok), 0);
        check("rst_cnt",    32'(dut.r_starve_cnt), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Inst only, accepted immediately, completes 3 cycles later
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; addr_ok = 1'b1;
        #1;
        check("t1_req",  32'(req), 1);
        check("t1_addr", addr, 32'h1FC0_0000);
        check("t1_iaok", 32'(inst_addr_ok), 1);
        check("t1_daok", 32'(data_addr_ok), 0);
        tick();
        inst_req = 1'b0; addr_ok = 1'b0;
        #1;
        check("t1_req_data", 32'(req), 0);
        check("t1_idok_c1",  32'(inst_data_ok), 0);
        tick();
        #1 check("t1_idok_c2", 32'(inst_data_ok), 0);
        tick();
        data_ok = 1'b1; rdata = 32'h2402_0001;
        #1;
        check("t1_idok",  32'(inst_data_ok), 1);
        check("t1_rdata", inst_rdata, 32'h2402_0001);
        check("t1_ddok",  32'(data_data_ok), 0);
        tick();
        data_ok = 1'b0;
        #1 check("t1_idle", 32'(dut.r_state), 32'(ST_IDLE));

        // Both request together with an empty counter: data wins, inst follows after the bubble
        inst_req = 1'b1; inst_addr = 32'h1FC0_0010;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        addr_ok = 1'b1;
        #1;
        check("t2_addr",  addr, 32'h8000_1000);
        check("t2_wr",    32'(wr), 1);
        check("t2_wdata", wdata, 32'hDEAD_BEEF);
        check("t2_daok",  32'(data_addr_ok), 1);
        check("t2_iaok",  32'(inst_addr_ok), 0);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_ok = 1'b1;
        #1;
        check("t2_bubble_req",  32'(req), 0);
        check("t2_bubble_iaok", 32'(inst_addr_ok), 0);
        check("t2_ddok",        32'(data_data_ok), 1);
        check("t2_idok",        32'(inst_data_ok), 0);
        tick();
        data_ok = 1'b0;
        #1;
        check("t2_cnt1",      32'(dut.r_starve_cnt), 1);
        check("t2_inst_req",  32'(req), 1);
        check("t2_inst_addr", addr, 32'h1FC0_0010);
        check("t2_inst_iaok", 32'(inst_addr_ok), 1);
        tick();
        inst_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1;
        #1 check("t2_inst_idok", 32'(inst_data_ok), 1);
        tick();
        data_ok = 1'b0;
        #1 check("t2_cnt0", 32'(dut.r_starve_cnt), 0);

        // Continuous contention: data wins 4 arbitrations, inst takes the 5th
        inst_req = 1'b1; data_req = 1'b1; addr_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t3_iaok_%0d", k), 32'(inst_addr_ok), (k == 4) ? 1 : 0);
            check($sformatf("t3_daok_%0d", k), 32'(data_addr_ok), (k == 4) ? 0 : 1);
            if (k == 4) check("t3_cnt_at_limit", 32'(dut.r_starve_cnt), 4);
            tick();
            data_ok = 1'b1;
            tick();
            data_ok = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0;
        #1 check("t3_cnt_clr", 32'(dut.r_starve_cnt), 0);
        tick();

        // Data held in ADDR for 5 cycles; inst rising mid-wait must not steal the bus
        data_req = 1'b1; data_addr = 32'h8000_2000; addr_ok = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) inst_req = 1'b1;
            #1;
            check($sformatf("t4_addr_%0d", c), addr, 32'h8000_2000);
            check($sformatf("t4_iaok_%0d", c), 32'(inst_addr_ok), 0);
            check($sformatf("t4_daok_%0d", c), 32'(data_addr_ok), 0);
            tick();
        end
        addr_ok = 1'b1;
        #1;
        check("t4_addr_acc", addr, 32'h8000_2000);
        check("t4_daok_acc", 32'(data_addr_ok), 1);
        check("t4_iaok_acc", 32'(inst_addr_ok), 0);
        tick();
        addr_ok = 1'b0; data_req = 1'b0; inst_req = 1'b0; data_ok = 1'b1;
        #1 check("t4_ddok", 32'(data_data_ok), 1);
        tick();
        data_ok = 1'b0;
        tick();

        // Reset mid-transaction; late data_ok after release is dropped
        inst_req = 1'b1; inst_addr = 32'h1FC0_0020; addr_ok = 1'b1;
        #1 check("t5_iaok", 32'(inst_addr_ok), 1);
        tick();
        addr_ok = 1'b0;
        #1 check("t5_in_data", 32'(dut.r_state), 32'(ST_DATA));
        resetn = 1'b0;
        #1;
        check("t5_rst_req",   32'(req), 0);
        check("t5_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("t5_rst_iaok",  32'(inst_addr_ok), 0);
        tick();
        inst_req = 1'b0; resetn = 1'b1;
        tick();
        tick();
        data_ok = 1'b1;
        #1;
        check("t5_late_idok", 32'(inst_data_ok), 0);
        check("t5_late_ddok", 32'(data_data_ok), 0);
        tick();
        data_ok = 1'b0;
        #1 check("t5_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Spurious data_ok in IDLE with no requests
        data_ok = 1'b1;
        #1;
        check("t6_idok", 32'(inst_data_ok), 0);
        check("t6_ddok", 32'(data_data_ok), 0);
        check("t6_req",  32'(req), 0);
        tick();
        data_ok = 1'b0;
        #1 check("t6_state", 32'(dut.r_state), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
